// File: rtl/ped_signal_if.sv
// ----------------------------------------------------------------------------
// ped_signal_if
// Bundles the vehicle-light inputs and the pedestrian lamp outputs that pass
// between the upstream traffic-light controller and the ped_signal stage.
//
//   Stop       hold, shared with the upstream controller
//   veh_g      vehicle green  (upstream Gout)
//   veh_y      vehicle yellow (upstream Yout)
//   veh_r      vehicle red    (upstream Rout)
//   walk       WALK lamp
//   dont_walk  DONT-WALK lamp (blinks while flashing)
//   countdown  remaining cycles in WALK/FLASH, 0 otherwise
//   fault      sticky illegal-input flag
//
// master: side that drives the vehicle lights and observes the lamps.
// slave : the ped_signal stage itself.
// ----------------------------------------------------------------------------
interface ped_signal_if #(
    parameter int CW = 4
);
    logic          Stop;
    logic          veh_g;
    logic          veh_y;
    logic          veh_r;
    logic          walk;
    logic          dont_walk;
    logic [CW-1:0] countdown;
    logic          fault;

    modport master (
        output Stop, veh_g, veh_y, veh_r,
        input  walk, dont_walk, countdown, fault
    );

    modport slave (
        input  Stop, veh_g, veh_y, veh_r,
        output walk, dont_walk, countdown, fault
    );
endinterface

// File: rtl/ped_signal.sv
// ----------------------------------------------------------------------------
// ped_signal
// Pedestrian crossing signal stage sitting directly downstream of the vehicle
// traffic-light controller. A rising vehicle red starts a solid WALK phase,
// followed by a flashing DONT-WALK phase, then solid DONT-WALK. A sticky fault
// detector forces DONT-WALK whenever the vehicle lights are illegal.
//
// Parameters
//   WALK_CYC   cycles of solid WALK after red onset (1..2^CW-1)
//   FLASH_CYC  cycles of flashing DONT-WALK after WALK (1..2^CW-1)
//   CW         countdown width (must match the interface CW)
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high; wins over every other input
//   bus    ped_signal_if.slave: Stop, veh_g/y/r in; walk, dont_walk,
//          countdown, fault out (all outputs registered)
// ----------------------------------------------------------------------------
module ped_signal #(
    parameter int WALK_CYC  = 6,
    parameter int FLASH_CYC = 4,
    parameter int CW        = 4
) (
    input  logic        clk,
    input  logic        reset,
    ped_signal_if.slave bus
);

    typedef enum logic [1:0] {
        ST_DONT,
        ST_WALK,
        ST_FLASH,
        ST_FAULT
    } state_t;

    localparam logic [CW-1:0] WALK_LOAD  = CW'(WALK_CYC - 1);
    localparam logic [CW-1:0] FLASH_LOAD = CW'(FLASH_CYC - 1);

    // Registered state
    state_t        state;
    logic [CW-1:0] cnt;
    logic          blink;
    logic          pend;
    logic          armed;
    logic          fault_q;
    logic          prev_g;
    logic          prev_y;
    logic          prev_r;
    logic          walk_q;
    logic          dont_walk_q;
    logic [CW-1:0] countdown_q;

    // Next-state values
    state_t        state_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          blink_nxt;
    logic          pend_nxt;
    logic          armed_nxt;
    logic          fault_nxt;
    logic          walk_nxt;
    logic          dont_walk_nxt;
    logic [CW-1:0] countdown_nxt;

    // Input qualification
    logic onehot;
    logic red_rise;
    logic fault_det;

    assign onehot = ( bus.veh_g & ~bus.veh_y & ~bus.veh_r) |
                    (~bus.veh_g &  bus.veh_y & ~bus.veh_r) |
                    (~bus.veh_g & ~bus.veh_y &  bus.veh_r);

    assign red_rise = bus.veh_r & ~prev_r;

    // Checks stay masked until the first legal one-hot pattern, so an upstream
    // block still coming out of reset (all-off or X) cannot trip the fault.
    // R->Y is the only illegal step between legal patterns; G->R and any->G
    // are legitimate upstream jumps.
    assign fault_det = armed & (~onehot | (prev_r & bus.veh_y));

    // NOTE: defaults are assigned first so every path drives every signal;
    // a missing assignment in combinational logic would infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        blink_nxt = blink;
        pend_nxt  = pend;
        fault_nxt = fault_q;
        armed_nxt = armed | onehot;

        if (state == ST_FAULT || fault_det) begin
            // Fault is absorbing and ignores Stop.
            state_nxt = ST_FAULT;
            cnt_nxt   = '0;
            blink_nxt = 1'b0;
            pend_nxt  = 1'b0;
            fault_nxt = 1'b1;
        end else if (!bus.veh_r) begin
            // Red ended (possibly early): abandon any crossing, drop a
            // pending request that never got served.
            pend_nxt = 1'b0;
            if (state != ST_DONT) begin
                state_nxt = ST_DONT;
                cnt_nxt   = '0;
                blink_nxt = 1'b0;
            end
        end else if (bus.Stop) begin
            // Frozen; only remember a red onset so it is served after release.
            if (state == ST_DONT && red_rise) begin
                pend_nxt = 1'b1;
            end
        end else begin
            unique case (state)
                ST_DONT: begin
                    if (red_rise || pend) begin
                        state_nxt = ST_WALK;
                        cnt_nxt   = WALK_LOAD;
                        pend_nxt  = 1'b0;
                    end
                end
                ST_WALK: begin
                    if (cnt == '0) begin
                        state_nxt = ST_FLASH;
                        cnt_nxt   = FLASH_LOAD;
                        blink_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_FLASH: begin
                    if (cnt == '0) begin
                        state_nxt = ST_DONT;
                        cnt_nxt   = '0;
                        blink_nxt = 1'b0;
                    end else begin
                        cnt_nxt   = cnt - 1'b1;
                        blink_nxt = ~blink;
                    end
                end
                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end
                default: begin
                    state_nxt = ST_DONT;
                end
            endcase
        end

        // Lamps are decoded from the next state so the registered outputs
        // line up with the state they describe.
        walk_nxt      = (state_nxt == ST_WALK);
        dont_walk_nxt = (state_nxt == ST_FLASH) ? blink_nxt
                                                : (state_nxt != ST_WALK);
        countdown_nxt = (state_nxt == ST_WALK || state_nxt == ST_FLASH)
                        ? cnt_nxt : '0;
    end

    // NOTE: non-blocking assignments so every register updates from the
    // values present before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_DONT;
            cnt         <= '0;
            blink       <= 1'b0;
            pend        <= 1'b0;
            armed       <= 1'b0;
            fault_q     <= 1'b0;
            prev_g      <= 1'b0;
            prev_y      <= 1'b0;
            prev_r      <= 1'b0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            countdown_q <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            blink       <= blink_nxt;
            pend        <= pend_nxt;
            armed       <= armed_nxt;
            fault_q     <= fault_nxt;
            // Sampled every cycle, Stop included, so edge detection stays
            // aligned with what upstream actually showed.
            prev_g      <= bus.veh_g;
            prev_y      <= bus.veh_y;
            prev_r      <= bus.veh_r;
            walk_q      <= walk_nxt;
            dont_walk_q <= dont_walk_nxt;
            countdown_q <= countdown_nxt;
        end
    end

    assign bus.walk      = walk_q;
    assign bus.dont_walk = dont_walk_q;
    assign bus.countdown = countdown_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_ped_signal.sv
// ----------------------------------------------------------------------------
// tb_ped_signal
// Directed self-checking bench for ped_signal. Inputs are driven 1 time unit
// after a rising edge; outputs are checked 1 time unit after the next edge.
// ----------------------------------------------------------------------------
module tb_ped_signal;

    localparam int CW        = 4;
    localparam int WALK_CYC  = 6;
    localparam int FLASH_CYC = 4;

    logic clk = 1'b0;
    logic reset;

    ped_signal_if #(.CW(CW)) bus ();

    ped_signal #(
        .WALK_CYC (WALK_CYC),
        .FLASH_CYC(FLASH_CYC),
        .CW       (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic g, input logic y, input logic r,
                         input logic stop);
        bus.veh_g = g;
        bus.veh_y = y;
        bus.veh_r = r;
        bus.Stop  = stop;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic w,
                              input logic dw, input int cd, input logic f);
        check({tag, "_walk"},  32'(bus.walk),      32'(w));
        check({tag, "_dwalk"}, 32'(bus.dont_walk), 32'(dw));
        check({tag, "_cd"},    32'(bus.countdown), 32'(cd));
        check({tag, "_fault"}, 32'(bus.fault),     32'(f));
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0);
        tick(2);
        expect_out("reset", 0, 1, 0, 0);
        reset = 1'b0;

        // Power-up all-off before arming must not fault.
        tick(2);
        expect_out("unarmed", 0, 1, 0, 0);

        // ---- 1: normal cycle, G then R held 20 cycles
        drive(1, 0, 0, 0);
        tick(3);
        expect_out("t1_green", 0, 1, 0, 0);
        drive(0, 0, 1, 0);
        for (int i = 0; i < WALK_CYC; i++) begin
            tick();
            expect_out($sformatf("t1_walk%0d", i), 1, 0, 5 - i, 0);
        end
        for (int i = 0; i < FLASH_CYC; i++) begin
            tick();
            expect_out($sformatf("t1_flash%0d", i), 0, (i % 2) == 0, 3 - i, 0);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out($sformatf("t1_done%0d", i), 0, 1, 0, 0);
        end
        drive(1, 0, 0, 0);
        tick();
        expect_out("t1_back_g", 0, 1, 0, 0);

        // ---- 2: red ends 3 cycles into WALK
        drive(0, 0, 1, 0);
        tick(3);
        expect_out("t2_walk", 1, 0, 3, 0);
        drive(1, 0, 0, 0);
        tick();
        expect_out("t2_abort", 0, 1, 0, 0);

        // ---- 3: Stop mid-WALK at countdown 3
        drive(0, 0, 1, 0);
        tick(3);
        expect_out("t3_pre", 1, 0, 3, 0);
        drive(0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out($sformatf("t3_hold%0d", i), 1, 0, 3, 0);
        end
        drive(0, 0, 1, 0);
        tick();
        expect_out("t3_resume", 1, 0, 2, 0);
        drive(1, 0, 0, 0);
        tick();
        expect_out("t3_end", 0, 1, 0, 0);

        // ---- 4: red rises while Stop held, served after release
        drive(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("t4_stop%0d", i), 0, 1, 0, 0);
        end
        drive(0, 0, 1, 0);
        tick();
        expect_out("t4_pend_walk", 1, 0, 5, 0);
        tick();
        expect_out("t4_walk_next", 1, 0, 4, 0);
        drive(1, 0, 0, 0);
        tick();
        expect_out("t4_end", 0, 1, 0, 0);

        // ---- 6: legal jumps G->Y->G (Set) and G->R (Jump)
        drive(0, 1, 0, 0);
        tick();
        expect_out("t6_g_to_y", 0, 1, 0, 0);
        drive(1, 0, 0, 0);
        tick();
        expect_out("t6_y_to_g", 0, 1, 0, 0);
        drive(0, 0, 1, 0);
        tick();
        expect_out("t6_jump_walk", 1, 0, 5, 0);

        // ---- 5a: R->Y step during WALK faults
        drive(0, 1, 0, 0);
        tick();
        expect_out("t5_r_to_y", 0, 1, 0, 1);
        drive(1, 0, 0, 0);
        tick(2);
        expect_out("t5a_sticky_g", 0, 1, 0, 1);
        drive(0, 0, 1, 0);
        tick(3);
        expect_out("t5a_sticky_r", 0, 1, 0, 1);

        // ---- 5b: G and Y together fault
        reset = 1'b1;
        tick();
        expect_out("t5_reset", 0, 1, 0, 0);
        reset = 1'b0;
        drive(1, 0, 0, 0);
        tick();
        expect_out("t5b_armed", 0, 1, 0, 0);
        drive(1, 1, 0, 0);
        tick();
        expect_out("t5_g_and_y", 0, 1, 0, 1);
        drive(1, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0);
        tick(4);
        expect_out("t5b_sticky_r", 0, 1, 0, 1);

        reset = 1'b1;
        tick();
        expect_out("final_reset", 0, 1, 0, 0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
